// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the 16-bit ALU and the multi-word
//                sequencer that drives it. This package holds the slice
//                width, the select codes, the mode codes and the state
//                encoding of the sequencer.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    // Width of one ALU slice. It matches the width of the ALU datapath.
    localparam int DATA_W = 16;

    // Select codes of the ALU. The same code has a different meaning in
    // arithmetic mode and in logic mode, so SEL_SUB and SEL_XOR share 4'b0110.
    localparam logic [3:0] SEL_ADD = 4'b1001;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_XOR = 4'b0110;
    localparam logic [3:0] SEL_AND = 4'b1011;
    localparam logic [3:0] SEL_OR  = 4'b1110;

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

    // States of the sequencer: accept, one slice per cycle, hold the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_wide_seq_if.sv
// ============================================================================
//  Module      : alu_wide_seq_if
//  Description : Bundle of the signals around alu_wide_seq. It groups three
//                buses:
//                  - the request handshake (req_*) from the operand source,
//                  - the slice bus to and from the 16-bit ALU (alu_*),
//                  - the response handshake (rsp_*) to writeback.
//                The slave modport is the sequencer's view. The master
//                modport is the view of the environment, which supplies the
//                requests, the ALU and the result consumer.
//  Parameters  : WORDS - number of DATA_W slices in one operand
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_wide_seq_if
    import alu_pkg::*;
#(
    parameter int WORDS = 4
);

    // Request side
    logic                      req_valid;
    logic                      req_ready;
    logic [WORDS*DATA_W-1:0]   req_a;
    logic [WORDS*DATA_W-1:0]   req_b;
    logic [3:0]                req_select;
    logic                      req_mode;
    logic                      req_carry_in;

    // ALU slice side
    logic [DATA_W-1:0]         alu_in_a;
    logic [DATA_W-1:0]         alu_in_b;
    logic [3:0]                alu_select;
    logic                      alu_mode;
    logic                      alu_carry_in;
    logic [DATA_W-1:0]         alu_result;
    logic                      alu_carry_out;

    // Response side
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [WORDS*DATA_W-1:0]   rsp_result;
    logic                      rsp_carry_out;
    logic                      rsp_zero;

    modport slave (
        input  req_valid, req_a, req_b, req_select, req_mode, req_carry_in,
        output req_ready,
        output alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in,
        input  alu_result, alu_carry_out,
        output rsp_valid, rsp_result, rsp_carry_out, rsp_zero,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_select, req_mode, req_carry_in,
        input  req_ready,
        input  alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in,
        output alu_result, alu_carry_out,
        input  rsp_valid, rsp_result, rsp_carry_out, rsp_zero,
        output rsp_ready
    );

endinterface

`default_nettype wire

// File: rtl/alu_wide_seq.sv
// ============================================================================
//  Module      : alu_wide_seq
//  Description : Runs WORDS*DATA_W-bit add/sub/logic operations on an
//                external DATA_W-bit ALU. It processes one slice per cycle,
//                starting with the least significant word. The carry out of
//                each slice is registered and fed into the next slice.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-high reset
//                bus  - alu_wide_seq_if.slave, which carries:
//                       req_*  request handshake and operands
//                       alu_*  slice drive to / result from the ALU
//                       rsp_*  response handshake and assembled result
//  Parameters  : WORDS - slices per operation (>= 1)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_wide_seq
    import alu_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_wide_seq_if.slave bus
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_RUN  = 2'(RUN);
    localparam logic [1:0] ST_DONE = 2'(DONE);

    logic [1:0]                    state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [WORDS-1:0][DATA_W-1:0]  a_q, a_d;
    logic [WORDS-1:0][DATA_W-1:0]  b_q, b_d;
    logic [WORDS-1:0][DATA_W-1:0]  res_q, res_d;
    logic [3:0]                    sel_q, sel_d;
    logic                          mode_q, mode_d;
    logic                          cin_q, cin_d;      // carry into slice 0
    logic                          carry_q, carry_d;  // carry out of the previous slice
    logic                          cout_q, cout_d;
    logic                          zero_q, zero_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sel_d   = sel_q;
        mode_d  = mode_q;
        cin_d   = cin_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        zero_d  = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    sel_d   = bus.req_select;
                    mode_d  = bus.req_mode;
                    cin_d   = bus.req_carry_in;
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                res_d[idx_q] = bus.alu_result;
                // For sub/dec selects the ALU's carry_out already means
                // "borrow". Passing it on unchanged is what the next slice
                // expects as its borrow in.
                carry_d      = bus.alu_carry_out;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                    cout_d  = (mode_q == MODE_LOGIC) ? 1'b0 : bus.alu_carry_out;
                    // The zero flag is taken from the result with the final
                    // word already merged in. It is captured on the same
                    // edge as that word.
                    zero_d  = (res_d == '0);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            ST_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sel_q   <= '0;
            mode_q  <= 1'b0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sel_q   <= sel_d;
            mode_q  <= mode_d;
            cin_q   <= cin_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
        end
    end

    // The slice bus is driven only from registers. Outside RUN it shows
    // slice 0 of the latched operands, so the ALU never sees X.
    assign bus.alu_in_a     = a_q[idx_q];
    assign bus.alu_in_b     = b_q[idx_q];
    assign bus.alu_select   = sel_q;
    assign bus.alu_mode     = mode_q;
    assign bus.alu_carry_in = (mode_q == MODE_LOGIC) ? 1'b0
                            : ((idx_q == '0) ? cin_q : carry_q);

    assign bus.req_ready     = (state_q == ST_IDLE);
    assign bus.rsp_valid     = (state_q == ST_DONE);
    assign bus.rsp_result    = res_q;
    assign bus.rsp_carry_out = cout_q;
    assign bus.rsp_zero      = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_wide_seq.sv
// ============================================================================
//  Module      : tb_alu_wide_seq
//  Description : Self-checking bench for alu_wide_seq with WORDS = 4. It
//                contains a reference 16-bit ALU, a wide-arithmetic model of
//                the expected handshake and results, and directed vectors
//                with hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_wide_seq;
    import alu_pkg::*;

    localparam int WORDS = 4;
    localparam int W     = WORDS * DATA_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_wide_seq_if #(.WORDS(WORDS)) bus ();

    alu_wide_seq #(.WORDS(WORDS)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference 16-bit ALU (combinational) ----------------
    function automatic logic [DATA_W:0] ref_alu(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                               input logic [3:0] sel, input logic mode, input logic cin);
        logic [DATA_W:0] r;
        if (mode) begin
            case (sel)
                4'b0110: r = {1'b0, a ^ b};
                4'b1011: r = {1'b0, a & b};
                4'b1110: r = {1'b0, a | b};
                default: r = {1'b0, ~a};
            endcase
        end else begin
            case (sel)
                4'b1001: r = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
                4'b0110: r = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, cin};
                default: r = {1'b0, a};
            endcase
        end
        return r;
    endfunction

    assign {bus.alu_carry_out, bus.alu_result} =
        ref_alu(bus.alu_in_a, bus.alu_in_b, bus.alu_select, bus.alu_mode, bus.alu_carry_in);

    // ---------------- behavioural model of the wide operation ----------------
    // Returns {carry/borrow out, result}, computed directly at full width.
    function automatic logic [W:0] wide_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] sel, input logic mode, input logic cin);
        logic [W:0] r;
        if (mode) begin
            case (sel)
                4'b0110: r = {1'b0, a ^ b};
                4'b1011: r = {1'b0, a & b};
                4'b1110: r = {1'b0, a | b};
                default: r = {1'b0, ~a};
            endcase
        end else begin
            case (sel)
                4'b1001: r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                4'b0110: r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
                default: r = {1'b0, a};
            endcase
        end
        return r;
    endfunction

    bit              m_busy  = 1'b0;
    bit              m_valid = 1'b0;
    int              m_cnt   = 0;
    int              m_acc   = 0;
    int              cyc     = 0;
    logic [W-1:0]    m_a, m_b;
    logic [3:0]      m_sel;
    logic            m_mode, m_cin;
    logic [W:0]      m_out;

    // Expected carry into slice k: the carry/borrow of the low k words.
    function automatic logic exp_cin(input int k);
        logic [W:0] msk, lo_a, lo_b, s;
        if (m_mode) return 1'b0;
        if (k == 0) return m_cin;
        msk  = ({{W{1'b0}}, 1'b1} << (k * DATA_W)) - 1'b1;
        lo_a = {1'b0, m_a} & msk;
        lo_b = {1'b0, m_b} & msk;
        case (m_sel)
            4'b1001: begin
                s = lo_a + lo_b + {{W{1'b0}}, m_cin};
                return s[k * DATA_W];
            end
            4'b0110: return (lo_a < lo_b + {{W{1'b0}}, m_cin});
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
        end else if (!m_busy) begin
            if (bus.req_valid) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_a    <= bus.req_a;
                m_b    <= bus.req_b;
                m_sel  <= bus.req_select;
                m_mode <= bus.req_mode;
                m_cin  <= bus.req_carry_in;
                m_acc  <= m_acc + 1;
            end
        end else if (!m_valid) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == WORDS - 1) begin
                m_valid <= 1'b1;
                m_out   <= wide_op(m_a, m_b, m_sel, m_mode, m_cin);
            end
        end else if (bus.rsp_ready) begin
            m_valid <= 1'b0;
            m_busy  <= 1'b0;
        end
    end

    // Compare process: checks the DUT against the model on every falling edge.
    always @(negedge clk) begin
        check("req_ready", bus.req_ready, !m_busy);
        check("rsp_valid", bus.rsp_valid, m_valid);
        if (m_valid) begin
            check("rsp_result", bus.rsp_result, m_out[W-1:0]);
            check("rsp_carry_out", bus.rsp_carry_out, m_out[W]);
            check("rsp_zero", bus.rsp_zero, (m_out[W-1:0] == '0));
        end
        if (m_busy && !m_valid) begin
            check("alu_in_a", bus.alu_in_a, m_a[m_cnt*DATA_W +: DATA_W]);
            check("alu_in_b", bus.alu_in_b, m_b[m_cnt*DATA_W +: DATA_W]);
            check("alu_carry_in", bus.alu_carry_in, exp_cin(m_cnt));
            check("alu_select", bus.alu_select, m_sel);
            check("alu_mode", bus.alu_mode, m_mode);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] sel, input logic mode, input logic cin);
        bus.req_a        = a;
        bus.req_b        = b;
        bus.req_select   = sel;
        bus.req_mode     = mode;
        bus.req_carry_in = cin;
    endtask

    task automatic wait_accept(input string name);
        int start;
        int k;
        start = m_acc;
        k = 0;
        bus.req_valid = 1'b1;
        while (m_acc == start && k < 20) begin
            step();
            k++;
        end
        if (m_acc == start) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_accept: no accept within %0d cycles, required 1", name, k);
        end
    endtask

    // Counts edges from the accept edge (which counts as edge 1) until rsp_valid is seen.
    task automatic wait_valid(input string name, input bit chk_cin0, output int edges);
        edges = 1;
        while (!bus.rsp_valid && edges < 20) begin
            if (chk_cin0) check({name, "_cin_forced0"}, bus.alu_carry_in, 1'b0);
            step();
            edges++;
        end
        if (!bus.rsp_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_valid: rsp_valid not seen after %0d edges, required 1", name, edges);
        end
    endtask

    task automatic handshake();
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    logic [W-1:0] v6_a   [3] = '{64'h1, 64'h1_0000, 64'hF0F0_F0F0_1234_5678};
    logic [W-1:0] v6_b   [3] = '{64'h2, 64'h1, 64'hFF00_0FF0_FFFF_0000};
    logic [3:0]   v6_sel [3] = '{4'b1001, 4'b0110, 4'b1011};
    logic         v6_mode[3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] v6_exp [3] = '{64'h3, 64'hFFFF, 64'hF000_00F0_1234_0000};

    initial begin
        int lat;
        int last;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        drive('0, '0, 4'b0000, 1'b0, 1'b0);
        step();
        step();

        // Reset state
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_result", bus.rsp_result, 64'h0);
        check("rst_rsp_carry", bus.rsp_carry_out, 1'b0);
        check("rst_rsp_zero", bus.rsp_zero, 1'b0);
        check("rst_alu_in_a", bus.alu_in_a, 16'h0);
        rst = 1'b0;
        step();

        // 1. ADD: carry from word 0 into word 1
        drive(64'h0000_0000_0000_FFFF, 64'h1, 4'b1001, 1'b0, 1'b0);
        wait_accept("t1");
        bus.req_valid = 1'b0;
        wait_valid("t1", 1'b0, lat);
        check("t1_latency_edges", lat, 5);
        check("t1_result", bus.rsp_result, 64'h0000_0000_0001_0000);
        check("t1_carry", bus.rsp_carry_out, 1'b0);
        check("t1_zero", bus.rsp_zero, 1'b0);
        handshake();

        // 2. SUB: the borrow ripples through all slices
        drive(64'h0, 64'h1, 4'b0110, 1'b0, 1'b0);
        wait_accept("t2");
        bus.req_valid = 1'b0;
        wait_valid("t2", 1'b0, lat);
        check("t2_result", bus.rsp_result, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t2_borrow", bus.rsp_carry_out, 1'b1);
        check("t2_zero", bus.rsp_zero, 1'b0);
        handshake();

        // 3. Logic XOR with carry_in = 1, which must be ignored
        drive(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 4'b0110, 1'b1, 1'b1);
        wait_accept("t3");
        bus.req_valid = 1'b0;
        wait_valid("t3", 1'b1, lat);
        check("t3_result", bus.rsp_result, 64'h0);
        check("t3_zero", bus.rsp_zero, 1'b1);
        check("t3_carry", bus.rsp_carry_out, 1'b0);
        handshake();

        // 4. Back-pressure: the result is held and a new request waits
        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 4'b1001, 1'b0, 1'b1);
        wait_accept("t4a");
        bus.req_valid = 1'b0;
        wait_valid("t4a", 1'b0, lat);
        drive(64'h5, 64'h3, 4'b0110, 1'b0, 1'b0);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_result", bus.rsp_result, 64'h0);
            check("t4_hold_carry", bus.rsp_carry_out, 1'b1);
            check("t4_hold_zero", bus.rsp_zero, 1'b1);
            check("t4_hold_req_ready", bus.req_ready, 1'b0);
            step();
        end
        handshake();
        wait_accept("t4b");
        bus.req_valid = 1'b0;
        wait_valid("t4b", 1'b0, lat);
        check("t4b_result", bus.rsp_result, 64'h2);
        check("t4b_borrow", bus.rsp_carry_out, 1'b0);
        handshake();

        // 5. Reset while slice 2 is on the ALU, then a clean operation
        drive(64'h0000_0000_0000_FFFF, 64'h1, 4'b1001, 1'b0, 1'b0);
        wait_accept("t5a");
        bus.req_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        check("t5_rst_req_ready", bus.req_ready, 1'b1);
        check("t5_rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("t5_rst_rsp_result", bus.rsp_result, 64'h0);
        rst = 1'b0;
        step();
        wait_accept("t5b");
        bus.req_valid = 1'b0;
        wait_valid("t5b", 1'b0, lat);
        check("t5b_result", bus.rsp_result, 64'h0000_0000_0001_0000);
        check("t5b_carry", bus.rsp_carry_out, 1'b0);
        handshake();

        // 6. Back-to-back with both handshakes held high
        bus.rsp_ready = 1'b1;
        last = 0;
        for (int i = 0; i < 3; i++) begin
            drive(v6_a[i], v6_b[i], v6_sel[i], v6_mode[i], 1'b0);
            wait_accept("t6");
            if (i > 0) check("t6_accept_interval", cyc - last, 6);
            last = cyc;
            wait_valid("t6", 1'b0, lat);
            check("t6_result_in_order", bus.rsp_result, v6_exp[i]);
        end
        bus.req_valid = 1'b0;
        repeat (8) step();
        bus.rsp_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
